hazard_ctrl: RTL

- Stall/flush/bypass controller for the in-order pipeline. Sits beside the IF/ID and ID/IX pipeline registers.
- Detects load-use hazards and inserts bubbles into ID/IX by driving its stall input.
- Squashes wrong-path instructions after a taken branch or jump resolved in IX.
- Computes the mx/wx/wm bypass selects that ID/IX latches alongside the instruction.
- Keeps stall and flush event counters for performance debug.

---
 rtl/hazard_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Stall/flush/bypass controller for the in-order pipeline.
// Detects load-use hazards and inserts bubbles into ID/IX. Squashes wrong-path
// instructions after a taken branch resolved in IX. Computes the MX/WX/WM
// bypass selects, and counts stall and flush events for performance debug.
module hazard_ctrl #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 2,
   parameter int CNT_W             = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_store_rt,
   input  logic [4:0]       ix_dest,
   input  logic             ix_write_reg,
   input  logic             ix_is_load,
   input  logic [4:0]       mem_dest,
   input  logic             mem_write_reg,
   input  logic             ix_branch_taken,
   output logic             pc_hold,
   output logic             if_id_hold,
   output logic             if_id_flush,
   output logic             id_ix_stall,
   output logic             id_ix_flush,
   output logic             mx_op1_bypass,
   output logic             mx_op2_bypass,
   output logic             wx_op1_bypass,
   output logic             wx_op2_bypass,
   output logic             wm_data_bypass,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, LSTALL, FLUSH} state_t;

   state_t           r_state, w_state_nxt;
   logic [2:0]       r_rem, w_rem_nxt;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
   logic             w_load_use;
   logic             w_ix_valid, w_mem_valid;
   logic             w_mx1, w_mx2;

   // $0 is hard-wired, so a producer targeting it never creates a dependency.
   assign w_ix_valid  = ix_write_reg  & (ix_dest  != 5'd0);
   assign w_mem_valid = mem_write_reg & (mem_dest != 5'd0);

   // A load in IX cannot forward in time for an ALU operand read by ID;
   // store data alone is covered later by the WM bypass, so it does not stall.
   assign w_load_use = ix_is_load & w_ix_valid &
                       ((id_uses_rs & (id_rs == ix_dest)) |
                        (id_uses_rt & (id_rt == ix_dest)));

   assign w_mx1 = id_uses_rs & w_ix_valid & ~ix_is_load & (ix_dest == id_rs);
   assign w_mx2 = id_uses_rt & w_ix_valid & ~ix_is_load & (ix_dest == id_rt);

   // Next-state and control outputs; branch outranks FLUSH, which outranks stalls.
   always_comb begin
      w_state_nxt    = r_state;
      w_rem_nxt      = r_rem;
      pc_hold        = 1'b0;
      if_id_hold     = 1'b0;
      if_id_flush    = 1'b0;
      id_ix_stall    = 1'b0;
      id_ix_flush    = 1'b0;
      mx_op1_bypass  = 1'b0;
      mx_op2_bypass  = 1'b0;
      wx_op1_bypass  = 1'b0;
      wx_op2_bypass  = 1'b0;
      wm_data_bypass = 1'b0;
      if (!rst_n) begin
         if_id_flush = 1'b1;
         id_ix_flush = 1'b1;
      end else if (ix_branch_taken) begin
         // Any stall in progress belongs to the wrong path and is dropped.
         if_id_flush = 1'b1;
         id_ix_flush = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            w_state_nxt = FLUSH;
            w_rem_nxt   = 3'(FLUSH_CYCLES - 1);
         end else begin
            w_state_nxt = RUN;
            w_rem_nxt   = 3'd0;
         end
      end else if (r_state == FLUSH) begin
         if_id_flush = 1'b1;
         id_ix_flush = 1'b1;
         w_rem_nxt   = r_rem - 3'd1;
         if (r_rem <= 3'd1) begin
            w_state_nxt = RUN;
            w_rem_nxt   = 3'd0;
         end
      end else if (r_state == LSTALL) begin
         pc_hold     = 1'b1;
         if_id_hold  = 1'b1;
         id_ix_stall = 1'b1;
         w_rem_nxt   = r_rem - 3'd1;
         if (r_rem <= 3'd1) begin
            w_state_nxt = RUN;
            w_rem_nxt   = 3'd0;
         end
      end else if (w_load_use) begin
         pc_hold     = 1'b1;
         if_id_hold  = 1'b1;
         id_ix_stall = 1'b1;
         if (LOAD_STALL_CYCLES > 1) begin
            w_state_nxt = LSTALL;
            w_rem_nxt   = 3'(LOAD_STALL_CYCLES - 1);
         end
      end else begin
         // MX is the youngest producer, so it shadows WX for the same operand.
         mx_op1_bypass  = w_mx1;
         mx_op2_bypass  = w_mx2;
         wx_op1_bypass  = id_uses_rs & w_mem_valid & (mem_dest == id_rs) & ~w_mx1;
         wx_op2_bypass  = id_uses_rt & w_mem_valid & (mem_dest == id_rt) & ~w_mx2;
         wm_data_bypass = id_store_rt & w_ix_valid & (ix_dest == id_rt);
      end
   end

   // State register and remaining-cycle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_rem   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
      end
   end

   // Saturating event counters: bubbles inserted and taken-branch flushes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (id_ix_stall && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (ix_branch_taken && (r_flush_cnt != {CNT_W{1'b1}}))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule
